// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_control_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         i_clr_n,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!i_clr_n)
            r_count <= '0;
        else if (i_en && (r_count != {W{1'b1}}))
            r_count <= r_count + W'(1);
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_control.sv
// Load-use bubble, memory-wait freeze and branch-flush sequencing for the
// 5-stage pipeline, with a saturating stall-cycle counter.
module hazard_control
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 15,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             idUsesRt,
    input  logic             exMemRead,
    input  logic [4:0]       exRt,
    input  logic             memStart,
    input  logic             memReady,
    input  logic             branchTaken,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             ifIdFlush,
    output logic             hazard,
    output logic             pipeFreeze,
    output logic             timeoutError,
    output logic [CNT_W-1:0] stallCount
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    hz_state_t       r_state, w_next_state;
    logic [WC_W-1:0] r_waitCnt, w_next_wait;
    logic [FC_W-1:0] r_flushCnt, w_next_flush;
    logic            r_timeoutError, w_set_te;
    logic            w_loadUse, w_memStall;

    assign w_loadUse  = exMemRead && (exRt != REG_ZERO) &&
                        ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
    assign w_memStall = memStart && !memReady;

    always_comb begin
        pcWrite      = 1'b1;
        ifIdWrite    = 1'b1;
        ifIdFlush    = 1'b0;
        hazard       = 1'b0;
        pipeFreeze   = 1'b0;
        w_next_state = r_state;
        w_next_wait  = r_waitCnt;
        w_next_flush = r_flushCnt;
        w_set_te     = 1'b0;

        case (r_state)
            RUN: begin
                if (w_memStall) begin
                    pcWrite      = 1'b0;
                    ifIdWrite    = 1'b0;
                    pipeFreeze   = 1'b1;
                    w_next_state = MEM_WAIT;
                    w_next_wait  = WC_W'(1);
                end else if (branchTaken) begin
                    ifIdFlush = 1'b1;
                    hazard    = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_next_state = FLUSH;
                        w_next_flush = FC_W'(FLUSH_CYCLES - 1);
                    end
                end else if (w_loadUse) begin
                    hazard    = 1'b1;
                    pcWrite   = 1'b0;
                    ifIdWrite = 1'b0;
                end
            end
            MEM_WAIT: begin
                // EX is frozen, so a pending branch/load-use is re-seen in RUN.
                pcWrite    = 1'b0;
                ifIdWrite  = 1'b0;
                pipeFreeze = 1'b1;
                if (memReady) begin
                    w_next_state = RUN;
                end else if (r_waitCnt == WC_W'(MEM_TIMEOUT)) begin
                    w_set_te     = 1'b1;
                    w_next_state = RUN;
                end else begin
                    w_next_wait = r_waitCnt + WC_W'(1);
                end
            end
            FLUSH: begin
                if (w_memStall) begin
                    pcWrite      = 1'b0;
                    ifIdWrite    = 1'b0;
                    pipeFreeze   = 1'b1;
                    w_next_state = MEM_WAIT;
                    w_next_wait  = WC_W'(1);
                end else begin
                    ifIdFlush = 1'b1;
                    hazard    = 1'b1;
                    if (r_flushCnt == FC_W'(1))
                        w_next_state = RUN;
                    else
                        w_next_flush = r_flushCnt - FC_W'(1);
                end
            end
            default: w_next_state = RUN;
        endcase

        // Reset overrides everything so the pipeline runs freely while held.
        if (!reset) begin
            pcWrite    = 1'b1;
            ifIdWrite  = 1'b1;
            ifIdFlush  = 1'b0;
            hazard     = 1'b0;
            pipeFreeze = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= RUN;
            r_waitCnt      <= '0;
            r_flushCnt     <= '0;
            r_timeoutError <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_waitCnt  <= w_next_wait;
            r_flushCnt <= w_next_flush;
            if (w_set_te)
                r_timeoutError <= 1'b1;
        end
    end

    assign timeoutError = r_timeoutError;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .i_clr_n (reset),
        .i_en    (!pcWrite),
        .o_count (stallCount)
    );

endmodule

// File: tb/tb_hazard_control.sv
// Directed-vector bench for hazard_control with a queue-based scoreboard.
module tb_hazard_control;

    localparam int CNT_W = 5;
    localparam logic [5:0] IDLE = 6'b110000;
    localparam logic [5:0] LU   = 6'b000100;
    localparam logic [5:0] FRZ  = 6'b000010;
    localparam logic [5:0] FL   = 6'b111100;
    localparam logic [5:0] TE   = 6'b000001;

    logic clk = 1'b0;
    logic reset, idUsesRt, exMemRead, memStart, memReady, branchTaken;
    logic [4:0] idRs, idRt, exRt;
    logic pcWrite, ifIdWrite, ifIdFlush, hazard, pipeFreeze, timeoutError;
    logic [CNT_W-1:0] stallCount;

    always #5 clk = ~clk;

    hazard_control #(.MEM_TIMEOUT(15), .FLUSH_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .exMemRead(exMemRead), .exRt(exRt), .memStart(memStart), .memReady(memReady),
        .branchTaken(branchTaken), .pcWrite(pcWrite), .ifIdWrite(ifIdWrite),
        .ifIdFlush(ifIdFlush), .hazard(hazard), .pipeFreeze(pipeFreeze),
        .timeoutError(timeoutError), .stallCount(stallCount)
    );

    typedef struct {
        string            nm;
        logic [5:0]       o;
        logic [CNT_W-1:0] c;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if ({pcWrite, ifIdWrite, ifIdFlush, hazard, pipeFreeze, timeoutError} !== e.o ||
                stallCount !== e.c) begin
                n_err++;
                $display("FAIL %s: got out=%b cnt=%0d, expected out=%b cnt=%0d", e.nm,
                         {pcWrite, ifIdWrite, ifIdFlush, hazard, pipeFreeze, timeoutError},
                         stallCount, e.o, e.c);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic mr, input logic [4:0] ert,
                        input logic [4:0] rs, input logic [4:0] rt, input logic u,
                        input logic ms, input logic rdy, input logic br,
                        input logic [5:0] eo, input int ec);
        exp_t x;
        reset = r; exMemRead = mr; exRt = ert; idRs = rs; idRt = rt; idUsesRt = u;
        memStart = ms; memReady = rdy; branchTaken = br;
        x.nm = nm; x.o = eo; x.c = CNT_W'(ec);
        q.push_back(x);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0; exMemRead = 1'b1; exRt = 5'd31; idRs = 5'd31; idRt = 5'd31;
        idUsesRt = 1'b1; memStart = 1'b1; memReady = 1'b1; branchTaken = 1'b1;
        @(posedge clk); #1;

        // reset with every input asserted
        step("rst_a",      0, 1, 31, 31, 31, 1, 1, 1, 1, IDLE, 0);
        step("rst_b",      0, 1, 31, 31, 31, 1, 1, 1, 1, IDLE, 0);
        // load-use on rs, then the bubble
        step("lu_rs",      1, 1,  8,  8,  0, 0, 0, 0, 0, LU,   0);
        step("lu_bubble",  1, 0,  8,  8,  0, 0, 0, 0, 0, IDLE, 1);
        // no hazard: r0 destination, rt not used
        step("lu_r0",      1, 1,  0,  0,  0, 1, 0, 0, 0, IDLE, 1);
        step("lu_nouse",   1, 1,  9,  3,  9, 0, 0, 0, 0, IDLE, 1);
        step("lu_rt",      1, 1,  9,  3,  9, 1, 0, 0, 0, LU,   1);
        step("lu_rt_bub",  1, 0,  9,  3,  9, 1, 0, 0, 0, IDLE, 2);
        // multi-cycle memory wait, load-use ignored while frozen
        step("mw_enter",   1, 0,  0,  0,  0, 0, 1, 0, 0, FRZ,  2);
        step("mw_2",       1, 0,  0,  0,  0, 0, 1, 0, 0, FRZ,  3);
        step("mw_lu_ign",  1, 1,  8,  8,  0, 0, 1, 0, 0, FRZ,  4);
        step("mw_4",       1, 0,  0,  0,  0, 0, 1, 0, 0, FRZ,  5);
        step("mw_ready",   1, 0,  0,  0,  0, 0, 1, 1, 0, FRZ,  6);
        step("mw_done",    1, 0,  0,  0,  0, 0, 0, 0, 0, IDLE, 7);
        step("mem_1cyc",   1, 0,  0,  0,  0, 0, 1, 1, 0, IDLE, 7);
        // branch beats load-use, three flush cycles
        step("br_over_lu", 1, 1,  8,  8,  0, 0, 0, 0, 1, FL,   7);
        step("fl_2",       1, 1,  8,  8,  0, 0, 0, 0, 0, FL,   7);
        step("fl_3",       1, 0,  0,  0,  0, 0, 0, 0, 0, FL,   7);
        step("fl_done",    1, 0,  0,  0,  0, 0, 0, 0, 0, IDLE, 7);
        // memory stall pre-empts a flush; remaining flush dropped
        step("br_b",       1, 0,  0,  0,  0, 0, 0, 0, 1, FL,   7);
        step("fl_preempt", 1, 0,  0,  0,  0, 0, 1, 0, 0, FRZ,  7);
        step("pre_ready",  1, 0,  0,  0,  0, 0, 0, 1, 0, FRZ,  8);
        step("pre_done",   1, 0,  0,  0,  0, 0, 0, 0, 0, IDLE, 9);
        // timeout: entry cycle plus 15 wait cycles
        step("to_enter",   1, 0,  0,  0,  0, 0, 1, 0, 0, FRZ,  9);
        for (int i = 0; i < 15; i++)
            step("to_wait", 1, 0, 0, 0, 0, 0, 0, 0, 0, FRZ, 10 + i);
        step("to_exit",    1, 0,  0,  0,  0, 0, 0, 0, 0, IDLE | TE, 25);
        // counter saturation at 31, error stays sticky
        for (int i = 0; i < 8; i++)
            step("sat", 1, 1, 8, 8, 0, 0, 0, 0, 0, LU | TE, (25 + i > 31) ? 31 : 25 + i);
        step("sat_hold",   1, 0,  0,  0,  0, 0, 0, 0, 0, IDLE | TE, 31);
        // reset clears error and counter
        step("rst_c",      0, 0,  0,  0,  0, 0, 0, 0, 0, IDLE | TE, 31);
        step("rst_d",      0, 0,  0,  0,  0, 0, 0, 0, 0, IDLE, 0);
        // branch coincident with memory stall, then reset mid-flush
        step("bm_enter",   1, 0,  0,  0,  0, 0, 1, 0, 1, FRZ,  0);
        step("bm_wait",    1, 0,  0,  0,  0, 0, 0, 0, 1, FRZ,  1);
        step("bm_ready",   1, 0,  0,  0,  0, 0, 0, 1, 1, FRZ,  2);
        step("bm_fl1",     1, 0,  0,  0,  0, 0, 0, 0, 1, FL,   3);
        step("bm_fl2_rst", 0, 0,  0,  0,  0, 0, 0, 0, 0, IDLE, 3);
        step("bm_idle",    1, 0,  0,  0,  0, 0, 0, 0, 0, IDLE, 0);
        step("bm_idle2",   1, 0,  0,  0,  0, 0, 0, 0, 0, IDLE, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
